// File: rtl/seq_detect_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_det_pkg : shared state encoding and default widths              |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package seq_det_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int WIN_W_DEF = 16;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_detect_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_detect_ctrl_if : config, serial stream and result handshake     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface seq_detect_ctrl_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int WIN_W = WIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [WIN_W-1:0] cfg_window;
  logic             start;
  logic             abort;
  logic             s_in;
  logic             s_valid;
  logic             busy;
  logic             cfg_err;
  logic             match_pulse;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  logic             res_overflow;

  modport master (
    output cfg_pattern, cfg_len, cfg_window, start, abort, s_in, s_valid, res_ready,
    input  busy, cfg_err, match_pulse, res_valid, res_count, res_overflow
  );

  modport slave (
    input  cfg_pattern, cfg_len, cfg_window, start, abort, s_in, s_valid, res_ready,
    output busy, cfg_err, match_pulse, res_valid, res_count, res_overflow
  );
endinterface
`default_nettype wire

// File: rtl/seq_detect_ctrl_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_match_core : non-overlapping serial pattern matcher             |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             hit,
  output logic             match
);
  localparam logic [LEN_W-1:0] c_fill_max = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] c_len_one  = LEN_W'(1);

  logic [PAT_W-1:0] shift_q, shift_d, mask;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [LEN_W:0]   fill_inc;
  logic             match_q;

  // hit is the same-cycle result so the parent can count on the sampling edge
  always_comb begin
    shift_d  = shift_q;
    fill_d   = fill_q;
    hit      = 1'b0;
    mask     = ~({PAT_W{1'b1}} << len);
    fill_inc = {1'b0, fill_q} + {1'b0, c_len_one};
    if (clr) begin
      shift_d = '0;
      fill_d  = '0;
    end else if (en) begin
      shift_d = (shift_q << 1) | PAT_W'(bit_in);
      hit     = (fill_inc >= {1'b0, len}) && ((shift_d & mask) == (pattern & mask));
      if (hit) begin
        fill_d = '0;
      end else if (fill_q != c_fill_max) begin
        fill_d = fill_inc[LEN_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      fill_q  <= fill_d;
      match_q <= hit;
    end
  end

  assign match = match_q;

endmodule
`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_detect_ctrl : run controller around the serial match core       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int WIN_W = WIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  seq_detect_ctrl_if.slave  bus
);
  localparam logic [LEN_W-1:0] c_len_max = LEN_W'(PAT_W);
  localparam logic [WIN_W-1:0] c_win_one = WIN_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             cfg_err_q, cfg_err_d;
  logic             cfg_ok, core_clr, core_en, core_hit, core_match;

  assign cfg_ok = (bus.cfg_len != '0) && (bus.cfg_len <= c_len_max) && (bus.cfg_window != '0);

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    win_d     = win_q;
    bitcnt_d  = bitcnt_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    cfg_err_d = 1'b0;
    core_clr  = 1'b0;
    core_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            pat_d    = bus.cfg_pattern;
            len_d    = bus.cfg_len;
            win_d    = bus.cfg_window;
            bitcnt_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            core_clr = 1'b1;
            state_d  = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // abort wins even over a final bit arriving in the same cycle
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.s_valid) begin
          core_en  = 1'b1;
          bitcnt_d = bitcnt_q + c_win_one;
          if (core_hit) begin
            if (count_q == c_cnt_max) ovf_d = 1'b1;
            else                      count_d = count_q + c_cnt_one;
          end
          if (bitcnt_d == win_q) state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (bus.abort || bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      win_q     <= '0;
      bitcnt_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      win_q     <= win_d;
      bitcnt_q  <= bitcnt_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  seq_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (core_clr),
    .en      (core_en),
    .bit_in  (bus.s_in),
    .pattern (pat_q),
    .len     (len_q),
    .hit     (core_hit),
    .match   (core_match)
  );

  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.res_valid    = (state_q == ST_REPORT);
  assign bus.res_count    = count_q;
  assign bus.res_overflow = ovf_q;
  assign bus.cfg_err      = cfg_err_q;
  assign bus.match_pulse  = core_match;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seq_detect_ctrl : directed vector bench for seq_detect_ctrl      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_seq_detect_ctrl;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  seq_detect_ctrl_if #(.PAT_W(8), .WIN_W(16), .CNT_W(8)) bus ();

  seq_detect_ctrl #(.PAT_W(8), .WIN_W(16), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // stream is first-bit-in-MSB over `window` bits; exp_mask bit i = match after bit i
  typedef struct {
    logic [7:0]  pattern;
    logic [3:0]  len;
    logic [15:0] window;
    logic [31:0] stream;
    logic [31:0] exp_mask;
    int          exp_count;
    logic        gaps;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] p, input logic [3:0] l, input logic [15:0] w);
    bus.cfg_pattern = p;
    bus.cfg_len     = l;
    bus.cfg_window  = w;
    bus.start       = 1'b1;
    step();
    bus.start       = 1'b0;
    bus.cfg_pattern = 8'($urandom);
    bus.cfg_len     = 4'($urandom);
    bus.cfg_window  = 16'($urandom);
  endtask

  task automatic feed_bit(input logic b, input logic gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        bus.s_valid = 1'b0;
        bus.s_in    = 1'($urandom);
        step();
      end
    end
    bus.s_in    = b;
    bus.s_valid = 1'b1;
    step();
    bus.s_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk({tag, "_valid_drop"}, bus.res_valid, 0);
    chk({tag, "_busy_drop"}, bus.busy, 0);
  endtask

  logic [31:0] obs;
  logic        early;
  int          idx;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_window = '0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.s_in = 1'b0; bus.s_valid = 1'b0;
    bus.res_ready = 1'b0;

    vecs[0] = '{8'hF6, 4'd4, 16'd12, 32'h66F, 32'h88,  2, 1'b0};
    vecs[1] = '{8'h05, 4'd3, 16'd5,  32'h15,  32'h4,   1, 1'b0};
    vecs[2] = '{8'h05, 4'd3, 16'd6,  32'h2D,  32'h24,  2, 1'b0};
    vecs[3] = '{8'hA5, 4'd8, 16'd10, 32'h14B, 32'h100, 1, 1'b0};
    vecs[4] = '{8'h01, 4'd1, 16'd4,  32'hB,   32'hD,   3, 1'b0};
    vecs[5] = '{8'h06, 4'd4, 16'd12, 32'h66F, 32'h88,  2, 1'b1};

    step(); step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_count", bus.res_count, 0);
    chk("rst_overflow", bus.res_overflow, 0);
    chk("rst_match", bus.match_pulse, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
    rst = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      do_start(vecs[v].pattern, vecs[v].len, vecs[v].window);
      chk("busy_after_start", bus.busy, 1);
      obs = '0;
      early = 1'b0;
      for (int i = 0; i < int'(vecs[v].window); i++) begin
        idx = int'(vecs[v].window) - 1 - i;
        feed_bit(vecs[v].stream[idx], vecs[v].gaps);
        if (bus.match_pulse) obs[i] = 1'b1;
        if (i < int'(vecs[v].window) - 1 && bus.res_valid) early = 1'b1;
      end
      chk("match_mask", obs, vecs[v].exp_mask);
      chk("early_valid", early, 0);
      chk("res_valid", bus.res_valid, 1);
      chk("res_count", bus.res_count, vecs[v].exp_count);
      chk("res_overflow", bus.res_overflow, 0);
      handshake("vec");
    end

    // illegal configurations
    do_start(8'h06, 4'd0, 16'd4);
    chk("len0_cfg_err", bus.cfg_err, 1);
    chk("len0_busy", bus.busy, 0);
    step();
    chk("len0_err_one_cycle", bus.cfg_err, 0);
    do_start(8'h06, 4'd4, 16'd0);
    chk("win0_cfg_err", bus.cfg_err, 1);
    chk("win0_busy", bus.busy, 0);
    do_start(8'h06, 4'd9, 16'd4);
    chk("len9_cfg_err", bus.cfg_err, 1);
    step();
    chk("illegal_no_result", bus.res_valid, 0);

    // saturation boundary: exactly 255 matches, then 300
    do_start(8'h01, 4'd1, 16'd255);
    for (int i = 0; i < 255; i++) feed_bit(1'b1, 1'b0);
    chk("sat255_count", bus.res_count, 255);
    chk("sat255_ovf", bus.res_overflow, 0);
    handshake("sat255");
    do_start(8'h01, 4'd1, 16'd300);
    for (int i = 0; i < 300; i++) feed_bit(1'b1, 1'b0);
    chk("sat300_valid", bus.res_valid, 1);
    chk("sat300_count", bus.res_count, 255);
    chk("sat300_ovf", bus.res_overflow, 1);
    handshake("sat300");

    // backpressure: result held, start ignored while reporting
    do_start(8'h06, 4'd4, 16'd12);
    for (int i = 0; i < 12; i++) feed_bit(vecs[0].stream[11 - i], 1'b0);
    bus.cfg_pattern = 8'h01; bus.cfg_len = 4'd1; bus.cfg_window = 16'd3;
    bus.start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_valid", bus.res_valid, 1);
      chk("bp_count", bus.res_count, 2);
      chk("bp_busy", bus.busy, 1);
    end
    bus.start = 1'b0;
    handshake("bp");

    // abort mid-run, then a clean run must count from zero
    do_start(8'h06, 4'd4, 16'd12);
    for (int i = 0; i < 5; i++) feed_bit(vecs[0].stream[11 - i], 1'b0);
    bus.abort = 1'b1; bus.s_valid = 1'b1; bus.s_in = 1'b1;
    step();
    bus.abort = 1'b0; bus.s_valid = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.res_valid, 0);
    for (int i = 0; i < 8; i++) feed_bit(1'b0, 1'b0);
    chk("abort_no_result", bus.res_valid, 0);
    do_start(8'h05, 4'd3, 16'd5);
    for (int i = 0; i < 5; i++) feed_bit(vecs[1].stream[4 - i], 1'b0);
    chk("post_abort_count", bus.res_count, 1);
    handshake("post_abort");

    // abort coinciding with the final window bit
    do_start(8'h01, 4'd1, 16'd3);
    feed_bit(1'b1, 1'b0); feed_bit(1'b1, 1'b0);
    bus.abort = 1'b1; bus.s_valid = 1'b1; bus.s_in = 1'b1;
    step();
    bus.abort = 1'b0; bus.s_valid = 1'b0;
    chk("abort_last_valid", bus.res_valid, 0);
    chk("abort_last_busy", bus.busy, 0);

    // reset mid-run and mid-report
    do_start(8'h05, 4'd3, 16'd6);
    for (int i = 0; i < 4; i++) feed_bit(vecs[2].stream[5 - i], 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_run_busy", bus.busy, 0);
    chk("rst_run_count", bus.res_count, 0);
    do_start(8'h05, 4'd3, 16'd6);
    for (int i = 0; i < 6; i++) feed_bit(vecs[2].stream[5 - i], 1'b0);
    chk("pre_rst_report_count", bus.res_count, 2);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_report_valid", bus.res_valid, 0);
    chk("rst_report_count", bus.res_count, 0);
    chk("rst_report_busy", bus.busy, 0);
    do_start(8'h05, 4'd3, 16'd5);
    for (int i = 0; i < 5; i++) feed_bit(vecs[1].stream[4 - i], 1'b0);
    chk("post_rst_count", bus.res_count, 1);
    chk("post_rst_valid", bus.res_valid, 1);
    handshake("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Run controller for a programmable serial pattern detector. Software or a parent FSM loads a pattern (up to PAT_W bits), a pattern length and a window length, then pulses `start`. The block feeds a qualified serial bit stream into a non-overlapping match core for exactly `cfg_window` valid bits. It then reports the match count through a valid/ready result handshake.

## Interface
- PAT_W, 8, maximum pattern length in bits
- LEN_W, $clog2(PAT_W+1), width of the length field
- WIN_W, 16, width of the window (valid-bit) counter
- CNT_W, 8, width of the match counter
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_pattern  in  PAT_W  pattern; bit cfg_len-1 is received first, bit 0 last
- cfg_len  in  LEN_W  pattern length, legal 1..PAT_W
- cfg_window  in  WIN_W  number of valid bits per run, legal ≥1
- start  in  1  run request, sampled only in IDLE
- abort  in  1  cancel run, no result produced
- s_in  in  1  serial data bit
- s_valid  in  1  s_in qualifier
- busy  out  1  high in RUN and REPORT
- cfg_err  out  1  one-cycle pulse on start with illegal config
- match_pulse  out  1  one-cycle pulse per detected match
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_count  out  CNT_W  matches in window, saturating
- res_overflow  out  1  counter saturated during run

## Operation
- Reset values: busy 0, cfg_err 0, match_pulse 0, res_valid 0, res_count 0, res_overflow 0; state IDLE; core history cleared.
- States: IDLE, RUN, REPORT.
- IDLE, start=1, cfg_len in 1..PAT_W and cfg_window≠0: latch pattern, length and window; clear the core, the bit counter, res_count and res_overflow; go to RUN.
- IDLE, start=1, illegal config: pulse cfg_err, stay in IDLE.
- RUN: each cycle with s_valid=1, shift s_in into the core and increment the bit counter. The core flags a match when fill ≥ len and the last len bits equal pattern[len-1:0]. On a match, fill is cleared, so matches are non-overlapping; the next match needs len fresh bits.
- Match counting: res_count increments by 1 per match. At all-ones it holds and res_overflow is set.
- End of window: when the cfg_window-th valid bit is sampled, go to REPORT. A match on that final bit is counted.
- REPORT: res_valid=1; res_count and res_overflow are held stable. On res_valid & res_ready, go to IDLE.
- abort=1 in RUN or REPORT: go to IDLE, res_valid drops, no handshake. abort has priority over end-of-window.
- start outside IDLE is ignored. Latched config is immune to input changes during a run.
- rst at any time: full reset to the reset values above, including mid-RUN and mid-REPORT.

## Timing
- start sampled at edge T → busy=1 from T+1. The first bit is sampled at edge T+1 if s_valid.
- Matching bit sampled at edge M → match_pulse high in cycle M+1, and res_count already incremented in that cycle.
- Final valid bit at edge L → res_valid=1 in cycle L+1, with the count including any match at L.
- Handshake at edge H (res_valid & res_ready) → res_valid=0 and busy=0 from H+1. The earliest new start is sampled at H+1.
- cfg_err is high in the cycle after the rejected start.
- s_valid gaps stall the run indefinitely; there is no timeout.

## Structure
- Package seq_det_pkg: state enum (IDLE, RUN, REPORT) and default values for PAT_W, WIN_W and CNT_W.
- Sub-module seq_match_core:
  - Inputs: clk, rst, clr, en, bit_in, pattern, len.
  - Output: registered match.
  - Internals: PAT_W shift register plus a fill counter that clears on match or clr.
- Top module: FSM, window counter, saturating match counter, result register.

## Test plan
- Pattern 4'b0110, len 4, window 12, stream 0110 0110 1111 → match_pulse after bits 4 and 8; res_count=2, res_overflow=0.
- Pattern 3'b101, len 3, window 5, stream 10101 → res_count=1 (the overlapping second occurrence is not counted). Stream 101101 with window 6 → res_count=2.
- CNT_W=8, pattern 1'b1, len 1, window 300, all ones → res_count=255, res_overflow=1.
- start with len=0, then with window=0 → cfg_err pulse each time; busy stays 0 and no result is produced.
- Backpressure: hold res_ready=0 for 5 cycles in REPORT → res_valid and res_count stable, start ignored. res_ready=1 → busy=0 next cycle.
- Random s_valid gaps with the 0110 stream → same count as the gap-free run. abort or rst mid-RUN → IDLE next cycle, res_valid never asserted, and the next run counts from 0.
